// File: rtl/rv_iopmp_req_frontend_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_iopmp_pkg / rv_iopmp_req_frontend_if                            |
// | Access-type encoding plus the AR/AW, response and checker bundle.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rv_iopmp_pkg;
  typedef enum logic [1:0] {
    ACCESS_NONE      = 2'd0,
    ACCESS_READ      = 2'd1,
    ACCESS_WRITE     = 2'd2,
    ACCESS_EXECUTION = 2'd3
  } access_t;
endpackage

interface rv_iopmp_req_frontend_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SID_WIDTH  = 8
);
  localparam int NB_WIDTH = $clog2(DATA_WIDTH / 8) + 1;

  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [ADDR_WIDTH-1:0] ar_addr_i;
  logic [2:0]            ar_size_i;
  logic [2:0]            ar_prot_i;
  logic [SID_WIDTH-1:0]  ar_sid_i;

  logic                  aw_valid_i;
  logic                  aw_ready_o;
  logic [ADDR_WIDTH-1:0] aw_addr_i;
  logic [2:0]            aw_size_i;
  logic [SID_WIDTH-1:0]  aw_sid_i;

  logic                  rd_rsp_valid_o;
  logic                  rd_rsp_ready_i;
  logic                  rd_rsp_allow_o;
  logic                  wr_rsp_valid_o;
  logic                  wr_rsp_ready_i;
  logic                  wr_rsp_allow_o;

  logic                  chk_ready_i;
  logic                  chk_en_o;
  logic [ADDR_WIDTH-1:0] chk_addr_o;
  logic [NB_WIDTH-1:0]   chk_num_bytes_o;
  logic [SID_WIDTH-1:0]  chk_sid_o;
  rv_iopmp_pkg::access_t chk_access_type_o;
  logic                  chk_valid_i;
  logic                  chk_allow_i;
  logic                  timeout_o;

  // Front-end side
  modport slave (
    input  ar_valid_i, ar_addr_i, ar_size_i, ar_prot_i, ar_sid_i,
    output ar_ready_o,
    input  aw_valid_i, aw_addr_i, aw_size_i, aw_sid_i,
    output aw_ready_o,
    output rd_rsp_valid_o, rd_rsp_allow_o, wr_rsp_valid_o, wr_rsp_allow_o,
    input  rd_rsp_ready_i, wr_rsp_ready_i,
    input  chk_ready_i, chk_valid_i, chk_allow_i,
    output chk_en_o, chk_addr_o, chk_num_bytes_o, chk_sid_o, chk_access_type_o,
    output timeout_o
  );

  // Requester / checker side
  modport master (
    output ar_valid_i, ar_addr_i, ar_size_i, ar_prot_i, ar_sid_i,
    input  ar_ready_o,
    output aw_valid_i, aw_addr_i, aw_size_i, aw_sid_i,
    input  aw_ready_o,
    input  rd_rsp_valid_o, rd_rsp_allow_o, wr_rsp_valid_o, wr_rsp_allow_o,
    output rd_rsp_ready_i, wr_rsp_ready_i,
    output chk_ready_i, chk_valid_i, chk_allow_i,
    input  chk_en_o, chk_addr_o, chk_num_bytes_o, chk_sid_o, chk_access_type_o,
    input  timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/rv_iopmp_req_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_iopmp_req_frontend                                              |
// | Round-robin AR/AW front-end issuing one IOPMP check at a time.     |
// | Optional verdict watchdog: define RV_IOPMP_REQ_TIMEOUT_EN.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rv_iopmp_req_frontend #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int SID_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  rv_iopmp_req_frontend_if.slave  bus
);
  import rv_iopmp_pkg::*;

  localparam int C_BYTES    = DATA_WIDTH / 8;
  localparam int C_MAX_SIZE = $clog2(C_BYTES);
  localparam int C_NB_WIDTH = C_MAX_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_prefer_wr;
  logic                  r_is_wr;
  logic                  r_ar_ready;
  logic                  r_aw_ready;
  logic                  r_chk_en;
  logic [ADDR_WIDTH-1:0] r_chk_addr;
  logic [C_NB_WIDTH-1:0] r_chk_nb;
  logic [SID_WIDTH-1:0]  r_chk_sid;
  access_t               r_chk_type;
  logic                  r_rd_rsp_valid;
  logic                  r_wr_rsp_valid;
  logic                  r_rd_allow;
  logic                  r_wr_allow;

  logic                  w_ar_acc;
  logic                  w_aw_acc;
  logic                  w_gnt_rd;
  logic                  w_gnt_wr;
  logic [2:0]            w_size;
  logic                  w_oversize;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [SID_WIDTH-1:0]  w_sid;
  access_t               w_type;
  logic                  w_rsp_ready;

  // Ready is registered, so a handshake needs only the held valid and a stale grant
  assign w_ar_acc = r_ar_ready & bus.ar_valid_i;
  assign w_aw_acc = r_aw_ready & bus.aw_valid_i;

  assign w_gnt_rd = bus.ar_valid_i & ~(bus.aw_valid_i & r_prefer_wr);
  assign w_gnt_wr = bus.aw_valid_i & ~(bus.ar_valid_i & ~r_prefer_wr);

  assign w_size     = w_aw_acc ? bus.aw_size_i : bus.ar_size_i;
  assign w_addr     = w_aw_acc ? bus.aw_addr_i : bus.ar_addr_i;
  assign w_sid      = w_aw_acc ? bus.aw_sid_i  : bus.ar_sid_i;
  assign w_oversize = 32'(w_size) > C_MAX_SIZE;
  assign w_type     = w_aw_acc        ? ACCESS_WRITE :
                      bus.ar_prot_i[2] ? ACCESS_EXECUTION : ACCESS_READ;

  assign w_rsp_ready = r_is_wr ? bus.wr_rsp_ready_i : bus.rd_rsp_ready_i;

`ifdef RV_IOPMP_REQ_TIMEOUT_EN
  localparam int C_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [C_CNT_WIDTH-1:0] r_wait_cnt;
  logic                   r_timeout;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_prefer_wr    <= 1'b0;
      r_is_wr        <= 1'b0;
      r_ar_ready     <= 1'b0;
      r_aw_ready     <= 1'b0;
      r_chk_en       <= 1'b0;
      r_chk_addr     <= '0;
      r_chk_nb       <= '0;
      r_chk_sid      <= '0;
      r_chk_type     <= ACCESS_NONE;
      r_rd_rsp_valid <= 1'b0;
      r_wr_rsp_valid <= 1'b0;
      r_rd_allow     <= 1'b0;
      r_wr_allow     <= 1'b0;
`ifdef RV_IOPMP_REQ_TIMEOUT_EN
      r_wait_cnt     <= '0;
      r_timeout      <= 1'b0;
`endif
    end else begin
`ifdef RV_IOPMP_REQ_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_ar_acc || w_aw_acc) begin
            r_ar_ready  <= 1'b0;
            r_aw_ready  <= 1'b0;
            r_is_wr     <= w_aw_acc;
            r_prefer_wr <= w_ar_acc;
            if (w_oversize) begin
              // Not checkable in one beat: deny without touching the checker
              r_rd_rsp_valid <= w_ar_acc;
              r_wr_rsp_valid <= w_aw_acc;
              r_rd_allow     <= 1'b0;
              r_wr_allow     <= 1'b0;
              r_state        <= RESP;
            end else begin
              r_chk_en   <= 1'b1;
              r_chk_addr <= w_addr;
              r_chk_nb   <= C_NB_WIDTH'(1) << w_size;
              r_chk_sid  <= w_sid;
              r_chk_type <= w_type;
              r_state    <= ISSUE;
            end
          end else begin
            r_ar_ready <= w_gnt_rd;
            r_aw_ready <= w_gnt_wr;
          end
        end
        ISSUE: begin
          if (bus.chk_ready_i) begin
            r_chk_en   <= 1'b0;
            r_chk_addr <= '0;
            r_chk_nb   <= '0;
            r_chk_sid  <= '0;
            r_chk_type <= ACCESS_NONE;
            r_state    <= WAIT;
`ifdef RV_IOPMP_REQ_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.chk_valid_i) begin
            r_rd_rsp_valid <= ~r_is_wr;
            r_wr_rsp_valid <= r_is_wr;
            r_rd_allow     <= ~r_is_wr & bus.chk_allow_i;
            r_wr_allow     <= r_is_wr & bus.chk_allow_i;
            r_state        <= RESP;
          end
`ifdef RV_IOPMP_REQ_TIMEOUT_EN
          else if (r_wait_cnt == C_CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            r_timeout      <= 1'b1;
            r_rd_rsp_valid <= ~r_is_wr;
            r_wr_rsp_valid <= r_is_wr;
            r_rd_allow     <= 1'b0;
            r_wr_allow     <= 1'b0;
            r_state        <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (w_rsp_ready) begin
            r_rd_rsp_valid <= 1'b0;
            r_wr_rsp_valid <= 1'b0;
            r_rd_allow     <= 1'b0;
            r_wr_allow     <= 1'b0;
            r_ar_ready     <= w_gnt_rd;
            r_aw_ready     <= w_gnt_wr;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ar_ready_o        = r_ar_ready;
  assign bus.aw_ready_o        = r_aw_ready;
  assign bus.chk_en_o          = r_chk_en;
  assign bus.chk_addr_o        = r_chk_addr;
  assign bus.chk_num_bytes_o   = r_chk_nb;
  assign bus.chk_sid_o         = r_chk_sid;
  assign bus.chk_access_type_o = r_chk_type;
  assign bus.rd_rsp_valid_o    = r_rd_rsp_valid;
  assign bus.wr_rsp_valid_o    = r_wr_rsp_valid;
  assign bus.rd_rsp_allow_o    = r_rd_allow;
  assign bus.wr_rsp_allow_o    = r_wr_allow;

`ifdef RV_IOPMP_REQ_TIMEOUT_EN
  assign bus.timeout_o = r_timeout;
`else
  // No watchdog in this build; the term only keeps TIMEOUT_CYCLES referenced
  assign bus.timeout_o = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_iopmp_req_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rv_iopmp_req_frontend                                           |
// | Directed + randomized bench with a transaction-level model.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rv_iopmp_req_frontend;
  import rv_iopmp_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  rv_iopmp_req_frontend_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW)) bus ();

  rv_iopmp_req_frontend #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  sid;
    logic [2:0]  prot;
  } req_t;

  req_t ar_req, aw_req;
  bit   ar_pend = 1'b0;
  bit   aw_pend = 1'b0;
  bit   last_wr = 1'b1;  // fresh reset: read is preferred
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  task automatic checkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checkw(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference rules, expressed on a whole request
  function automatic bit exp_oversize(req_t r);
    return (1 << r.size) > (DW / 8);
  endfunction

  function automatic logic [63:0] exp_nb(req_t r);
    return 64'(1) << r.size;
  endfunction

  function automatic access_t exp_type(bit wr, req_t r);
    if (wr) return ACCESS_WRITE;
    return r.prot[2] ? ACCESS_EXECUTION : ACCESS_READ;
  endfunction

  function automatic req_t mk_req(logic [63:0] a, logic [2:0] s, logic [7:0] id, logic [2:0] p);
    req_t r;
    r.addr = a; r.size = s; r.sid = id; r.prot = p;
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk_req({$urandom, $urandom}, 3'($urandom_range(0, 4)), 8'($urandom), 3'($urandom));
  endfunction

  task automatic post_ar(input req_t r);
    ar_req = r; ar_pend = 1'b1;
    bus.ar_valid_i = 1'b1; bus.ar_addr_i = r.addr; bus.ar_size_i = r.size;
    bus.ar_sid_i = r.sid; bus.ar_prot_i = r.prot;
  endtask

  task automatic post_aw(input req_t r);
    aw_req = r; aw_pend = 1'b1;
    bus.aw_valid_i = 1'b1; bus.aw_addr_i = r.addr; bus.aw_size_i = r.size;
    bus.aw_sid_i = r.sid;
  endtask

  task automatic check_rsp(input string tag, input bit wr, input bit valid, input bit allow);
    check1({tag, "_rd_valid"}, bus.rd_rsp_valid_o, !wr && valid);
    check1({tag, "_wr_valid"}, bus.wr_rsp_valid_o, wr && valid);
    if (valid) check1({tag, "_allow"}, wr ? bus.wr_rsp_allow_o : bus.rd_rsp_allow_o, allow);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_ar_ready"}, bus.ar_ready_o, 1'b0);
    check1({tag, "_aw_ready"}, bus.aw_ready_o, 1'b0);
    check1({tag, "_rd_valid"}, bus.rd_rsp_valid_o, 1'b0);
    check1({tag, "_wr_valid"}, bus.wr_rsp_valid_o, 1'b0);
    check1({tag, "_rd_allow"}, bus.rd_rsp_allow_o, 1'b0);
    check1({tag, "_wr_allow"}, bus.wr_rsp_allow_o, 1'b0);
    check1({tag, "_chk_en"}, bus.chk_en_o, 1'b0);
    checkw({tag, "_chk_addr"}, bus.chk_addr_o, 64'd0);
    checkw({tag, "_chk_nb"}, 64'(bus.chk_num_bytes_o), 64'd0);
    checkw({tag, "_chk_sid"}, 64'(bus.chk_sid_o), 64'd0);
    checkw({tag, "_chk_type"}, 64'(bus.chk_access_type_o), 64'(ACCESS_NONE));
    check1({tag, "_timeout"}, bus.timeout_o, 1'b0);
  endtask

  // One full transaction: arbitration, check issue, verdict, response
  task automatic serve(input bit allow, input int lat, input int chk_stall,
                       input int rsp_stall, input bit refill);
    bit   got_wr, exp_wr;
    req_t r;
    int   waited = 0;
    while (!((bus.ar_ready_o && bus.ar_valid_i) || (bus.aw_ready_o && bus.aw_valid_i))
           && waited < 20) begin
      tick();
      waited++;
    end
    check1("accept_bound", waited < 20, 1'b1);
    if (waited >= 20) return;
    check1("one_ready", bus.ar_ready_o && bus.aw_ready_o, 1'b0);
    got_wr = bus.aw_ready_o && bus.aw_valid_i;
    exp_wr = (ar_pend && aw_pend) ? !last_wr : aw_pend;
    check1("grant_port", got_wr, exp_wr);
    r = got_wr ? aw_req : ar_req;
    last_wr = got_wr;
    tick();
    if (got_wr) begin bus.aw_valid_i = 1'b0; aw_pend = 1'b0; end
    else        begin bus.ar_valid_i = 1'b0; ar_pend = 1'b0; end
    check1("ready_drop", bus.ar_ready_o || bus.aw_ready_o, 1'b0);
    if (exp_oversize(r)) begin
      check1("oversize_no_chk", bus.chk_en_o, 1'b0);
      check_rsp("oversize_rsp", got_wr, 1'b1, 1'b0);
    end else begin
      check1("chk_en", bus.chk_en_o, 1'b1);
      checkw("chk_addr", bus.chk_addr_o, r.addr);
      checkw("chk_nb", 64'(bus.chk_num_bytes_o), exp_nb(r));
      checkw("chk_sid", 64'(bus.chk_sid_o), 64'(r.sid));
      checkw("chk_type", 64'(bus.chk_access_type_o), 64'(exp_type(got_wr, r)));
      for (int s = 0; s < chk_stall; s++) begin
        if (s == 0) begin bus.chk_valid_i = 1'b1; bus.chk_allow_i = 1'b1; end
        tick();
        bus.chk_valid_i = 1'b0; bus.chk_allow_i = 1'b0;
        check1("stall_chk_en", bus.chk_en_o, 1'b1);
        checkw("stall_chk_addr", bus.chk_addr_o, r.addr);
        checkw("stall_chk_type", 64'(bus.chk_access_type_o), 64'(exp_type(got_wr, r)));
        check1("stall_no_rsp", bus.rd_rsp_valid_o || bus.wr_rsp_valid_o, 1'b0);
      end
      bus.chk_ready_i = 1'b1;
      tick();
      bus.chk_ready_i = 1'b0;
      check1("chk_en_drop", bus.chk_en_o, 1'b0);
      checkw("chk_addr_idle", bus.chk_addr_o, 64'd0);
      checkw("chk_type_idle", 64'(bus.chk_access_type_o), 64'(ACCESS_NONE));
      repeat (lat) tick();
      check1("wait_no_rsp", bus.rd_rsp_valid_o || bus.wr_rsp_valid_o, 1'b0);
      bus.chk_valid_i = 1'b1; bus.chk_allow_i = allow;
      tick();
      bus.chk_valid_i = 1'b0; bus.chk_allow_i = 1'b0;
      check_rsp("verdict_rsp", got_wr, 1'b1, allow);
    end
    for (int s = 0; s < rsp_stall; s++) begin
      tick();
      check_rsp("rsp_hold", got_wr, 1'b1, exp_oversize(r) ? 1'b0 : allow);
    end
    if (refill) begin
      if (got_wr) post_aw(rand_req());
      else        post_ar(rand_req());
    end
    if (got_wr) bus.wr_rsp_ready_i = 1'b1; else bus.rd_rsp_ready_i = 1'b1;
    tick();
    bus.wr_rsp_ready_i = 1'b0; bus.rd_rsp_ready_i = 1'b0;
    check_rsp("rsp_done", got_wr, 1'b0, 1'b0);
  endtask

  // Drives a pending AR through issue and leaves the block waiting for a verdict
  task automatic reach_wait();
    int waited = 0;
    while (!(bus.ar_ready_o && bus.ar_valid_i) && waited < 20) begin
      tick();
      waited++;
    end
    check1("rw_accept_bound", waited < 20, 1'b1);
    last_wr = 1'b0;
    tick();
    bus.ar_valid_i = 1'b0; ar_pend = 1'b0;
    bus.chk_ready_i = 1'b1;
    tick();
    bus.chk_ready_i = 1'b0;
    check1("rw_chk_en_low", bus.chk_en_o, 1'b0);
  endtask

  initial begin
    bus.ar_valid_i = 1'b0; bus.ar_addr_i = '0; bus.ar_size_i = '0; bus.ar_prot_i = '0;
    bus.ar_sid_i = '0;
    bus.aw_valid_i = 1'b0; bus.aw_addr_i = '0; bus.aw_size_i = '0; bus.aw_sid_i = '0;
    bus.rd_rsp_ready_i = 1'b0; bus.wr_rsp_ready_i = 1'b0;
    bus.chk_ready_i = 1'b0; bus.chk_valid_i = 1'b0; bus.chk_allow_i = 1'b0;
    rst_i = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick();

    // Both valid from reset: R, W, then R, W again
    post_ar(mk_req(64'h1000, 3'd2, 8'd1, 3'd0));
    post_aw(mk_req(64'h2000, 3'd3, 8'd5, 3'd0));
    serve(1'b1, 0, 0, 0, 1'b0);
    serve(1'b0, 1, 0, 0, 1'b0);
    post_ar(mk_req(64'h3000, 3'd1, 8'd7, 3'd0));
    post_aw(mk_req(64'h4000, 3'd0, 8'd9, 3'd0));
    serve(1'b1, 0, 0, 0, 1'b0);
    serve(1'b1, 2, 0, 0, 1'b0);

    // Single read
    post_ar(mk_req(64'h8000_0000, 3'd3, 8'd2, 3'd0));
    serve(1'b1, 1, 0, 0, 1'b0);

    // Instruction fetch, denied
    post_ar(mk_req(64'h8000_1000, 3'd2, 8'd3, 3'b100));
    serve(1'b0, 0, 0, 0, 1'b0);

    // Oversize write
    post_aw(mk_req(64'h9000_0000, 3'd4, 8'd4, 3'd0));
    serve(1'b1, 0, 0, 0, 1'b0);

    // Checker back-pressure and response back-pressure
    post_aw(mk_req(64'hA000_0040, 3'd3, 8'd6, 3'd0));
    serve(1'b1, 0, 5, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (!ar_pend && !aw_pend) begin
        int m;
        m = $urandom_range(1, 3);
        if (m[0]) post_ar(rand_req());
        if (m[1]) post_aw(rand_req());
      end
      serve(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2; i++) begin
      if (ar_pend || aw_pend) serve(1'b1, 0, 0, 0, 1'b0);
    end

    // Long verdict wait
    post_ar(mk_req(64'hB000_0000, 3'd3, 8'd8, 3'd0));
    reach_wait();
`ifdef RV_IOPMP_REQ_TIMEOUT_EN
    repeat (TO - 1) tick();
    check1("pre_expiry_no_rsp", bus.rd_rsp_valid_o, 1'b0);
    check1("pre_expiry_timeout", bus.timeout_o, 1'b0);
    tick();
    check1("expiry_timeout", bus.timeout_o, 1'b1);
    check_rsp("expiry_rsp", 1'b0, 1'b1, 1'b0);
    tick();
    check1("timeout_pulse_end", bus.timeout_o, 1'b0);
    bus.rd_rsp_ready_i = 1'b1;
    tick();
    bus.rd_rsp_ready_i = 1'b0;
`else
    repeat (TO + 4) tick();
    check1("no_watchdog_timeout", bus.timeout_o, 1'b0);
    check1("no_watchdog_rsp", bus.rd_rsp_valid_o, 1'b0);
    bus.chk_valid_i = 1'b1; bus.chk_allow_i = 1'b1;
    tick();
    bus.chk_valid_i = 1'b0; bus.chk_allow_i = 1'b0;
    check_rsp("late_verdict", 1'b0, 1'b1, 1'b1);
    bus.rd_rsp_ready_i = 1'b1;
    tick();
    bus.rd_rsp_ready_i = 1'b0;
`endif
    check_rsp("long_wait_done", 1'b0, 1'b0, 1'b0);

    // Reset while waiting for a verdict aborts silently
    post_ar(mk_req(64'hC000_0000, 3'd3, 8'd9, 3'd0));
    reach_wait();
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst_i = 1'b0;
    last_wr = 1'b1;
    bus.chk_valid_i = 1'b1; bus.chk_allow_i = 1'b1;
    tick();
    bus.chk_valid_i = 1'b0; bus.chk_allow_i = 1'b0;
    repeat (2) tick();
    check_rsp("post_reset_silent", 1'b0, 1'b0, 1'b0);

    // Pointer back to read-preferred after reset
    post_aw(mk_req(64'hD000_0000, 3'd2, 8'd10, 3'd0));
    post_ar(mk_req(64'hD000_1000, 3'd1, 8'd11, 3'd4));
    serve(1'b1, 0, 0, 0, 1'b0);
    serve(1'b0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
